// File: rtl/alu_seq_ctrl_if.sv
// Bundle between the control unit, the 16-bit sequencer and the shared 8-bit alu.
// The sequencer uses the slave modport. The control unit and alu side use the master modport.
interface alu_seq_ctrl_if #(
    parameter int ALU_OP_W = 9
) ();
    logic                start_i;
    logic [1:0]          cmd_i;
    logic [15:0]         a_i;
    logic [15:0]         b_i;
    logic [7:0]          alu_rs_o;
    logic [7:0]          alu_rt_o;
    logic [ALU_OP_W-1:0] alu_op_o;
    logic [7:0]          alu_result_i;
    logic                alu_carry_i;
    logic                busy_o;
    logic                done_o;
    logic [15:0]         result_o;
    logic                carry_o;
    logic                neg_o;
    logic                zero_o;
    logic                err_o;

    modport slave (
        input  start_i, cmd_i, a_i, b_i, alu_result_i, alu_carry_i,
        output alu_rs_o, alu_rt_o, alu_op_o,
        output busy_o, done_o, result_o, carry_o, neg_o, zero_o, err_o
    );

    modport master (
        output start_i, cmd_i, a_i, b_i, alu_result_i, alu_carry_i,
        input  alu_rs_o, alu_rt_o, alu_op_o,
        input  busy_o, done_o, result_o, carry_o, neg_o, zero_o, err_o
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer that builds 16-bit ADD/SUB/LSL from low, high and carry fix-up passes on an 8-bit alu.
// Optional build macro ALU_SEQ_CONST_LATENCY_EN always visits FIX, which gives a fixed latency.
module alu_seq_ctrl #(
    parameter int   ALU_OP_W = 9,
    parameter logic OP_LSB   = 1'b0
) (
    input  logic           clk_i,
    input  logic           reset_i,
    alu_seq_ctrl_if.slave  bus
);
    localparam int OPC_W = ALU_OP_W - 1;
    localparam logic [OPC_W-1:0] OPC_NOP = OPC_W'(0);
    localparam logic [OPC_W-1:0] OPC_ADD = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_SUB = OPC_W'(2);
    localparam logic [OPC_W-1:0] OPC_LSL = OPC_W'(3);
    localparam logic [OPC_W-1:0] OPC_OR  = OPC_W'(4);

    localparam logic [1:0] CMD_ADD = 2'b00;
    localparam logic [1:0] CMD_SUB = 2'b01;
    localparam logic [1:0] CMD_LSL = 2'b10;
    localparam logic [1:0] CMD_RSV = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [7:0]  lo_q, lo_d, hi_q, hi_d;
    logic        c_lo_q, c_lo_d, c_hi_q, c_hi_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [15:0] result_q, result_d;
    logic        carry_q, carry_d, neg_q, neg_d, zero_q, zero_d, err_q, err_d;

    logic [OPC_W-1:0] opc;
    logic [OPC_W-1:0] cmd_opc;
    logic [7:0]       rs, rt;
    logic             is_lsl;

    assign is_lsl = (cmd_q == CMD_LSL);
    always_comb begin
        case (cmd_q)
            CMD_SUB: cmd_opc = OPC_SUB;
            CMD_LSL: cmd_opc = OPC_LSL;
            default: cmd_opc = OPC_ADD;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start_i) state_d = (bus.cmd_i == CMD_RSV) ? S_DONE : S_LO;
            S_LO:   state_d = S_HI;
`ifdef ALU_SEQ_CONST_LATENCY_EN
            S_HI:   state_d = S_FIX;
`else
            S_HI:   state_d = c_lo_q ? S_FIX : S_DONE;
`endif
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // alu drive; the fix-up operand is c_lo itself so a skipped carry adds/ORs zero
    always_comb begin
        rs  = 8'h00;
        rt  = 8'h00;
        opc = OPC_NOP;
        case (state_q)
            S_LO: begin
                rs  = a_q[7:0];
                rt  = is_lsl ? 8'h01 : b_q[7:0];
                opc = cmd_opc;
            end
            S_HI: begin
                rs  = a_q[15:8];
                rt  = is_lsl ? 8'h01 : b_q[15:8];
                opc = cmd_opc;
            end
            S_FIX: begin
                rs  = hi_q;
                rt  = {7'b0, c_lo_q};
                opc = is_lsl ? OPC_OR : cmd_opc;
            end
            default: ;
        endcase
    end

    assign bus.alu_rs_o = rs;
    assign bus.alu_rt_o = rt;
    assign bus.alu_op_o = {opc, OP_LSB};

    // Datapath and registered outputs
    always_comb begin
        logic        fin;
        logic [15:0] fin_res;
        logic        fin_c;
        a_d = a_q; b_d = b_q; cmd_d = cmd_q;
        lo_d = lo_q; hi_d = hi_q; c_lo_d = c_lo_q; c_hi_d = c_hi_q;
        result_d = result_q; carry_d = carry_q; neg_d = neg_q; zero_d = zero_q; err_d = err_q;
        busy_d  = (state_d == S_LO) || (state_d == S_HI) || (state_d == S_FIX);
        done_d  = 1'b0;
        fin     = 1'b0;
        fin_res = 16'h0000;
        fin_c   = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start_i) begin
                a_d   = bus.a_i;
                b_d   = bus.b_i;
                cmd_d = bus.cmd_i;
                err_d = 1'b0;
                if (bus.cmd_i == CMD_RSV) begin
                    fin   = 1'b1;
                    err_d = 1'b1;
                end
            end
            S_LO: begin
                lo_d   = bus.alu_result_i;
                c_lo_d = bus.alu_carry_i;
            end
            S_HI: begin
                hi_d    = bus.alu_result_i;
                c_hi_d  = bus.alu_carry_i;
                fin     = (state_d == S_DONE);
                fin_res = {bus.alu_result_i, lo_q};
                fin_c   = bus.alu_carry_i;
            end
            S_FIX: begin
                hi_d    = bus.alu_result_i;
                fin     = 1'b1;
                fin_res = {bus.alu_result_i, lo_q};
                fin_c   = c_hi_q | (bus.alu_carry_i & ~is_lsl);
            end
            default: ;
        endcase
        if (fin) begin
            done_d   = 1'b1;
            result_d = fin_res;
            carry_d  = fin_c;
            neg_d    = fin_res[15];
            zero_d   = (fin_res == 16'h0000);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_q <= '0; b_q <= '0; cmd_q <= '0;
            lo_q <= '0; hi_q <= '0; c_lo_q <= 1'b0; c_hi_q <= 1'b0;
            busy_q <= 1'b0; done_q <= 1'b0; result_q <= '0;
            carry_q <= 1'b0; neg_q <= 1'b0; zero_q <= 1'b0; err_q <= 1'b0;
        end else begin
            a_q <= a_d; b_q <= b_d; cmd_q <= cmd_d;
            lo_q <= lo_d; hi_q <= hi_d; c_lo_q <= c_lo_d; c_hi_q <= c_hi_d;
            busy_q <= busy_d; done_q <= done_d; result_q <= result_d;
            carry_q <= carry_d; neg_q <= neg_d; zero_q <= zero_d; err_q <= err_d;
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.carry_o  = carry_q;
    assign bus.neg_o    = neg_q;
    assign bus.zero_o   = zero_q;
    assign bus.err_o    = err_q;
endmodule
